// File: rtl/uart_num_parser_pkg.sv
// rtl/uart_num_parser_pkg.sv - shared ASCII constants, FSM state and byte-class encodings
package uart_num_parser_pkg;

    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_NINE  = 8'h39;
    localparam logic [7:0] ASCII_DEL   = 8'h7F;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIGITS  = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        CLS_DIGIT = 3'd0,
        CLS_TERM  = 3'd1,
        CLS_BS    = 3'd2,
        CLS_SPACE = 3'd3,
        CLS_OTHER = 3'd4
    } byte_class_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
    endfunction

endpackage

// File: rtl/uart_char_class.sv
// rtl/uart_char_class.sv - combinational ASCII byte classifier with decimal digit extraction
module uart_char_class
    import uart_num_parser_pkg::*;
(
    input  logic [7:0]  data,
    output byte_class_t cls,
    output logic [3:0]  digit
);

    always_comb begin
        cls   = CLS_OTHER;
        digit = 4'd0;
        if (is_digit(data)) begin
            cls   = CLS_DIGIT;
            digit = data[3:0];
        end else if (data == ASCII_CR || data == ASCII_LF) begin
            cls = CLS_TERM;
        end else if (data == ASCII_BS || data == ASCII_DEL) begin
            cls = CLS_BS;
        end else if (data == ASCII_SPACE) begin
            cls = CLS_SPACE;
        end
    end

endmodule

// File: rtl/uart_num_parser.sv
// rtl/uart_num_parser.sv - assembles typed ASCII decimal digits into a binary value per line
module uart_num_parser
    import uart_num_parser_pkg::*;
#(
    parameter int VAL_W      = 16,
    parameter int MAX_DIGITS = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_vld,
    input  logic [7:0]       din_data,
    output logic             num_vld,
    output logic [VAL_W-1:0] num_data,
    output logic             num_err,
    output logic             busy
);

    localparam int CNT_W  = $clog2(MAX_DIGITS + 1);
    localparam int CAND_W = VAL_W + 4;
    localparam logic [CAND_W-1:0] VAL_MAX = {4'b0000, {VAL_W{1'b1}}};

    state_t             state;
    logic [VAL_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    byte_class_t        cls;
    logic [3:0]         digit;
    logic [CAND_W-1:0]  cand;
    logic [VAL_W-1:0]   acc_div;

    uart_char_class u_class (
        .data  (din_data),
        .cls   (cls),
        .digit (digit)
    );

    // Four guard bits cover acc*10+9 so overflow is detected before truncation.
    assign cand    = ({4'b0000, acc} * CAND_W'(10)) + CAND_W'(digit);
    assign acc_div = acc / VAL_W'(10);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            acc      <= '0;
            cnt      <= '0;
            num_vld  <= 1'b0;
            num_err  <= 1'b0;
            num_data <= '0;
            busy     <= 1'b0;
        end else begin
            num_vld <= 1'b0;
            num_err <= 1'b0;
            if (din_vld) begin
                case (state)
                    ST_IDLE: begin
                        case (cls)
                            CLS_DIGIT: begin
                                acc   <= VAL_W'(digit);
                                cnt   <= CNT_W'(1);
                                state <= ST_DIGITS;
                                busy  <= 1'b1;
                            end
                            CLS_OTHER: begin
                                state <= ST_DISCARD;
                                busy  <= 1'b1;
                            end
                            default: ;
                        endcase
                    end

                    ST_DIGITS: begin
                        case (cls)
                            CLS_DIGIT: begin
                                if (cnt == CNT_W'(MAX_DIGITS) || cand > VAL_MAX) begin
                                    state <= ST_DISCARD;
                                end else begin
                                    acc <= cand[VAL_W-1:0];
                                    cnt <= cnt + CNT_W'(1);
                                end
                            end
                            CLS_BS: begin
                                acc <= acc_div;
                                cnt <= cnt - CNT_W'(1);
                                if (cnt == CNT_W'(1)) begin
                                    state <= ST_IDLE;
                                    busy  <= 1'b0;
                                end
                            end
                            CLS_TERM: begin
                                num_data <= acc;
                                num_vld  <= 1'b1;
                                acc      <= '0;
                                cnt      <= '0;
                                state    <= ST_IDLE;
                                busy     <= 1'b0;
                            end
                            default: begin
                                state <= ST_DISCARD;
                            end
                        endcase
                    end

                    ST_DISCARD: begin
                        if (cls == CLS_TERM) begin
                            num_err <= 1'b1;
                            acc     <= '0;
                            cnt     <= '0;
                            state   <= ST_IDLE;
                            busy    <= 1'b0;
                        end
                    end

                    default: begin
                        acc   <= '0;
                        cnt   <= '0;
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
